// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin lock arbiter.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_e;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Callers guarantee at most one bit is set, so OR-ing indices is exact.
    function automatic logic [4:0] onehot2idx(input logic [31:0] oh);
        logic [4:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (oh[i]) idx = idx | 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotated-priority picker: first eligible request at or above ptr, wrapping.
module rr_pick
    import arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned IDX_W     = 2
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    input  logic [NUM_PORTS-1:0] mask_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 valid_o
);

    logic [NUM_PORTS-1:0]   eligible;
    logic [2*NUM_PORTS-1:0] dbl_req;
    logic [NUM_PORTS-1:0]   rot_gnt;
    logic [2*NUM_PORTS-1:0] dbl_gnt;
    logic                   found;

    always_comb begin
        eligible = req_i & ~mask_i;
        // Doubling the vector lets a plain right shift act as a rotate.
        dbl_req  = {eligible, eligible} >> ptr_i;
        rot_gnt  = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (dbl_req[i] && !found) begin
                rot_gnt[i] = 1'b1;
                found      = 1'b1;
            end
        end
        dbl_gnt = {{NUM_PORTS{1'b0}}, rot_gnt} << ptr_i;
        gnt_o   = dbl_gnt[NUM_PORTS-1:0] | dbl_gnt[2*NUM_PORTS-1:NUM_PORTS];
        valid_o = |eligible;
        idx_o   = IDX_W'(onehot2idx(32'(gnt_o)));
    end

endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with a registered grant held until done/abandon.
// Optional forced release after MAX_HOLD owned cycles with ARB_HOLD_TIMEOUT_EN.
module rr_lock_arbiter
    import arb_pkg::*;
#(
    parameter  int unsigned NUM_PORTS = 4,
    parameter  int unsigned MAX_HOLD  = 16,
    localparam int unsigned IDX_W     = idx_w(NUM_PORTS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic                 done_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic [IDX_W-1:0]     gnt_idx_o,
    output logic                 busy_o,
    output logic                 timeout_o
);

    if (NUM_PORTS < 1 || NUM_PORTS > 32) begin : g_bad_ports
        $error("rr_lock_arbiter: NUM_PORTS must be 1..32");
    end
    if (MAX_HOLD < 1) begin : g_bad_hold
        $error("rr_lock_arbiter: MAX_HOLD must be >= 1");
    end

    arb_state_e           state_q, state_d;
    logic [NUM_PORTS-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic                 timeout_q, timeout_d;

    logic [NUM_PORTS-1:0] pick_gnt;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;
    logic                 owner_req;
    logic                 release_ev;
    logic                 new_grant;
    logic                 tmo_hit;

    // gnt_q is all-zero in IDLE, so it doubles as the owner mask.
    rr_pick #(
        .NUM_PORTS(NUM_PORTS),
        .IDX_W    (IDX_W)
    ) u_pick (
        .req_i  (req_i),
        .ptr_i  (ptr_q),
        .mask_i (gnt_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .valid_o(pick_valid)
    );

`ifdef ARB_HOLD_TIMEOUT_EN
    localparam int unsigned HOLD_W = idx_w(MAX_HOLD);
    logic [HOLD_W-1:0] hold_q, hold_d;

    always_comb begin
        tmo_hit = (state_q == ARB_OWNED) && (hold_q == HOLD_W'(MAX_HOLD - 1));
        hold_d  = hold_q;
        if (new_grant) begin
            hold_d = '0;
        end else if (state_q == ARB_OWNED) begin
            hold_d = hold_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) hold_q <= '0;
        else       hold_q <= hold_d;
    end
`else
    always_comb tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        idx_d      = idx_q;
        ptr_d      = ptr_q;
        owner_req  = |(req_i & gnt_q);
        release_ev = (state_q == ARB_OWNED) && (done_i || !owner_req || tmo_hit);
        new_grant  = (state_q == ARB_IDLE || release_ev) && pick_valid;
        // Timeout is reported only when it is the sole reason for release.
        timeout_d  = release_ev && tmo_hit && !done_i && owner_req;

        if (state_q == ARB_IDLE || release_ev) begin
            if (pick_valid) begin
                state_d = ARB_OWNED;
                gnt_d   = pick_gnt;
                idx_d   = pick_idx;
                ptr_d   = (pick_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : pick_idx + 1'b1;
            end else begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
                idx_d   = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ARB_IDLE;
            gnt_q     <= '0;
            idx_q     <= '0;
            ptr_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign gnt_idx_o = idx_q;
    assign busy_o    = (state_q == ARB_OWNED);
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Scoreboard bench for rr_lock_arbiter (4-port and 1-port instances).
module tb_rr_lock_arbiter;

    localparam int N  = 4;
    localparam int MH = 4;
`ifdef ARB_HOLD_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, done;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gidx;
    logic       busy, tmo;

    logic       rst1, done1;
    logic [0:0] req1;
    logic [0:0] gnt1;
    logic [0:0] gidx1;
    logic       busy1, tmo1;

    rr_lock_arbiter #(.NUM_PORTS(N), .MAX_HOLD(MH)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .done_i(done),
        .gnt_o(gnt), .gnt_idx_o(gidx), .busy_o(busy), .timeout_o(tmo)
    );

    rr_lock_arbiter #(.NUM_PORTS(1), .MAX_HOLD(MH)) dut1 (
        .clk_i(clk), .rst_i(rst1), .req_i(req1), .done_i(done1),
        .gnt_o(gnt1), .gnt_idx_o(gidx1), .busy_o(busy1), .timeout_o(tmo1)
    );

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       busy;
        logic       tmo;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp1_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state for the 4-port instance.
    bit m_owned = 1'b0;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_cnt   = 0;

    function automatic int pick(input logic [3:0] rq, input int excl);
        for (int k = 0; k < N; k++) begin
            int p;
            p = (m_ptr + k) % N;
            if (rq[p] && p != excl) return p;
        end
        return -1;
    endfunction

    task automatic take(input int w);
        m_owned = 1'b1;
        m_owner = w;
        m_ptr   = (w + 1) % N;
        m_cnt   = 0;
    endtask

    task automatic cycle(input logic [3:0] rq, input logic d, input logic r);
        bit   rel, tev;
        int   w;
        exp_t e, o;
        req  = rq;
        done = d;
        rst  = r;
        tev  = 1'b0;
        if (r) begin
            m_owned = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0;
        end else if (!m_owned) begin
            w = pick(rq, -1);
            if (w >= 0) take(w);
        end else begin
            rel = d || !rq[m_owner];
            if (TMO && !rel && m_cnt == MH - 1) begin
                rel = 1'b1;
                tev = 1'b1;
            end
            if (rel) begin
                w = pick(rq, m_owner);
                if (w >= 0) take(w);
                else begin m_owned = 1'b0; m_owner = 0; end
            end else begin
                m_cnt++;
            end
        end
        e.gnt  = m_owned ? 4'(1 << m_owner) : 4'b0;
        e.idx  = m_owned ? 2'(m_owner) : 2'd0;
        e.busy = m_owned;
        e.tmo  = tev;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        o = exp_q.pop_front();
        check("gnt", 32'(gnt), 32'(o.gnt));
        check("gnt_idx", 32'(gidx), 32'(o.idx));
        check("busy", 32'(busy), 32'(o.busy));
        check("timeout", 32'(tmo), 32'(o.tmo));
    endtask

    task automatic cycle1(input logic rq, input logic d, input logic r, input logic eg);
        exp_t e, o;
        req1  = rq;
        done1 = d;
        rst1  = r;
        e.gnt = {3'b0, eg}; e.idx = 2'd0; e.busy = eg; e.tmo = 1'b0;
        exp1_q.push_back(e);
        @(posedge clk);
        #1;
        o = exp1_q.pop_front();
        check("p1_gnt", 32'(gnt1), 32'(o.gnt[0]));
        check("p1_idx", 32'(gidx1), 32'(o.idx[0]));
        check("p1_busy", 32'(busy1), 32'(o.busy));
        check("p1_timeout", 32'(tmo1), 32'(o.tmo));
    endtask

    initial begin
        req = '0; done = 1'b0; rst = 1'b1;
        req1 = '0; done1 = 1'b0; rst1 = 1'b1;

        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0000, 1'b0, 1'b1);
        check("reset_gnt", 32'(gnt), 32'h0);

        // req 1010 from reset: port 1 wins, ptr moves to 2 so port 3 follows
        cycle(4'b1010, 1'b0, 1'b0);
        check("first_gnt", 32'(gnt), 32'b0010);
        check("first_idx", 32'(gidx), 32'd1);
        cycle(4'b1010, 1'b1, 1'b0);
        check("ptr_after_1", 32'(gnt), 32'b1000);
        cycle(4'b0000, 1'b0, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0);
        check("done_idle", 32'(busy), 32'd0);

        // all four requesting: order 0,1,2,3,0 with no bubble
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b1111, 1'b0, 1'b0);
        check("rr_first", 32'(gidx), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            cycle(4'b1111, 1'b0, 1'b0);
            cycle(4'b1111, 1'b0, 1'b0);
            cycle(4'b1111, 1'b1, 1'b0);
            check("rr_order", 32'(gidx), 32'(k % N));
            check("rr_nobubble", 32'(busy), 32'd1);
        end

        // owner 2 abandons while port 0 waits; then port 0 done alone
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0100, 1'b0, 1'b0);
        cycle(4'b0101, 1'b0, 1'b0);
        check("hold_owner2", 32'(gnt), 32'b0100);
        cycle(4'b0001, 1'b0, 1'b0);
        check("abandon_move", 32'(gnt), 32'b0001);
        cycle(4'b0000, 1'b1, 1'b0);
        check("done_release", 32'(gnt), 32'h0);

        // reset mid-ownership by port 3, then 1 and 3 together -> 1
        cycle(4'b1000, 1'b0, 1'b0);
        check("owner3", 32'(gnt), 32'b1000);
        cycle(4'b1000, 1'b0, 1'b1);
        check("rst_drop", 32'(gnt), 32'h0);
        cycle(4'b1010, 1'b0, 1'b0);
        check("post_rst_pick", 32'(gnt), 32'b0010);

        // releasing port must not win again straight away
        cycle(4'b1010, 1'b1, 1'b0);
        cycle(4'b1010, 1'b1, 1'b0);
        check("no_immediate_regrant", 32'(gnt), 32'b0010);

        // hold behaviour: port 1 owns with no done, port 2 waiting
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0010, 1'b0, 1'b0);
        for (int i = 1; i <= 100; i++) begin
            cycle(4'b0110, 1'b0, 1'b0);
`ifdef ARB_HOLD_TIMEOUT_EN
            if (i == 4) begin
                check("tmo_gnt", 32'(gnt), 32'b0100);
                check("tmo_pulse", 32'(tmo), 32'd1);
            end
`else
            if (i == 100) begin
                check("hold_forever", 32'(gnt), 32'b0010);
                check("no_tmo", 32'(tmo), 32'd0);
            end
`endif
        end

        // single-port instance: grant, done with req held, one idle cycle, re-grant
        cycle1(1'b0, 1'b0, 1'b1, 1'b0);
        cycle1(1'b1, 1'b0, 1'b0, 1'b1);
        cycle1(1'b1, 1'b0, 1'b0, 1'b1);
        cycle1(1'b1, 1'b1, 1'b0, 1'b0);
        cycle1(1'b1, 1'b0, 1'b0, 1'b1);
        cycle1(1'b0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_lock_arbiter.md
Name: rr_lock_arbiter

Overview:
Parametrised round-robin arbiter with a registered one-hot grant. It succeeds the combinational fixed-priority arbiter in the same arbitration layer, where several masters share one downstream resource. A grant is held across a multi-cycle transaction until the owner signals completion or drops its request. Rotating priority removes the starvation inherent in fixed priority. An optional hold-timeout forces rotation.

Parameters:
NUM_PORTS, 4, number of requesters; legal range 1..32
MAX_HOLD, 16, maximum grant-held cycles before forced release; used only with the timeout feature; legal range >= 1

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  synchronous active-high reset
req_i  input  NUM_PORTS  per-port request level; held high for the whole transaction
done_i  input  1  completion pulse from the current owner; ignored when no grant is active
gnt_o  output  NUM_PORTS  registered one-hot grant, or all-zero
gnt_idx_o  output  IDX_W  binary index of the owner; IDX_W = max(1, $clog2(NUM_PORTS)); 0 when idle
busy_o  output  1  high while any grant is active (equals |gnt_o)
timeout_o  output  1  one-cycle pulse when a grant is force-released; tied 0 when the feature is out

Behaviour:
- Reset: rst_i is sampled on the clock edge. When asserted, the next edge sets gnt_o=0, gnt_idx_o=0, busy_o=0, timeout_o=0, state=IDLE, ptr=0 (port 0 highest priority) and hold counter=0. Reset mid-transaction drops the grant without a done handshake.
- State machine has two states:
  - IDLE: if any req_i bit is set, grant the winner at the next edge and go to OWNED.
  - OWNED: hold gnt_o constant until a release event occurs.
- Release event (OWNED only) is any of:
  - done_i=1
  - req_i[owner]=0 (abandon)
  - timeout (feature on)
  Simultaneous events count as a single release.
- On release, arbitration runs in the same cycle over the current req_i with the owner's bit masked.
  - Another requester present: the grant moves directly to it at the next edge, with no idle bubble.
  - No other requester: gnt_o goes to 0 and the state goes to IDLE.
  - The releasing port can win again only after one idle cycle, or when it is the sole requester seen in IDLE.
- Winner selection: the first set req bit scanning from index ptr upward, wrapping modulo NUM_PORTS. Whenever a grant is issued, ptr <= winner+1 (wrapping to 0).
- Latency: req_i rising in cycle N with the arbiter IDLE gives gnt_o high in cycle N+1. There is no combinational path from req_i to gnt_o.
- gnt_idx_o and busy_o are registered together with gnt_o and are always mutually consistent.
- NUM_PORTS=1: ptr is constant 0 and gnt_idx_o is always 0; behaviour is otherwise unchanged.
- done_i while IDLE has no effect. A request newly rising while another port is OWNED waits without affecting the owner.

Optional Feature:
Macro ARB_HOLD_TIMEOUT_EN.
- Defined:
  - A hold counter clears on every new grant and increments each OWNED cycle.
  - When the counter reaches MAX_HOLD-1 with no other release event, that cycle is a release event. timeout_o pulses high for one cycle, aligned with the edge where the grant changes.
  - If done_i coincides with the timeout cycle, it is a normal release and timeout_o stays 0.
- Not defined: no counter is instantiated, the grant is held indefinitely, and timeout_o is constant 0.

Decomposition:
- Package arb_pkg holds:
  - state enum arb_state_e {ARB_IDLE, ARB_OWNED}
  - function idx_w(n) returning max(1, $clog2(n))
  - one-hot-to-index function onehot2idx
- One combinational sub-module, rr_pick:
  - Inputs: req vector, ptr, and a mask of the current owner bit.
  - Outputs: one-hot winner, winner index, any_valid.
  - Implemented as a rotated fixed-priority scan (double-width request trick).
- The top level contains the FSM, the registers and the optional counter.

Test Plan:
- Reset then req_i=4'b1010 in cycle 2 -> gnt_o=4'b0010, gnt_idx_o=1 in cycle 3; ptr=2.
- All four request continuously, each pulsing done_i after 3 owned cycles -> grant order 0,1,2,3,0 with no idle cycle between owners.
- Port 2 owner drops req_i while port 0 requests -> gnt_o=4'b0001 next edge. Then port 0 done with no requesters -> gnt_o=0, busy_o=0.
- rst_i asserted while port 3 owns -> gnt_o=0 the next edge. The next request from ports 1 and 3 together grants port 1.
- With ARB_HOLD_TIMEOUT_EN and MAX_HOLD=4: port 1 holds with no done while port 2 requests -> timeout_o pulses and gnt_o=4'b0100 exactly 4 cycles after the grant. Without the macro, port 1 still owns after 100 cycles and timeout_o=0.
- NUM_PORTS=1: req_i=1 -> gnt_o=1; done_i with req held -> one idle cycle, then re-grant.
